// File: rtl/turn_charge_fsm.sv
// Turn controller for one player: waits for a fresh fire-key press while the
// player owns the turn, charges a power level while the key is held, flies
// the projectile for a fixed time, then pulses turn_done. An unanswered turn
// is forfeited after an idle timeout. All outputs are registered and carry
// the decode of the state being entered.
module turn_charge_fsm #(
    parameter int unsigned THROW_TICKS        = 65_000_000,
    parameter int unsigned PWR_W              = 8,
    parameter int unsigned PWR_STEP_TICKS     = 250_000,
    parameter int unsigned IDLE_TIMEOUT_TICKS = 650_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             space,
    input  logic             my_turn,
    output logic             enable_draw,
    output logic [1:0]       index,
    output logic             space_pin_tx,
    output logic             throw_enable,
    output logic [PWR_W-1:0] power,
    output logic             turn_done,
    output logic             timed_out
);

    // Counter widths: each counter only ever holds 0 .. TICKS-1.
    localparam int unsigned THROW_W = (THROW_TICKS > 1) ? $clog2(THROW_TICKS) : 1;
    localparam int unsigned STEP_W  = (PWR_STEP_TICKS > 1) ? $clog2(PWR_STEP_TICKS) : 1;
    localparam int unsigned IDLE_W  = (IDLE_TIMEOUT_TICKS > 1) ? $clog2(IDLE_TIMEOUT_TICKS) : 1;

    localparam bit TIMEOUT_EN = (IDLE_TIMEOUT_TICKS > 0);

    // Terminal values; the idle one is unused when the timeout is disabled.
    localparam logic [THROW_W-1:0] THROW_LAST = THROW_W'(THROW_TICKS - 1);
    localparam logic [STEP_W-1:0]  STEP_LAST  = STEP_W'(PWR_STEP_TICKS - 1);
    localparam logic [IDLE_W-1:0]  IDLE_LAST  =
        IDLE_W'((IDLE_TIMEOUT_TICKS > 0) ? IDLE_TIMEOUT_TICKS - 1 : 0);

    localparam logic [PWR_W-1:0] PWR_MAX = {PWR_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CHARGE = 2'd1,
        THROW  = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t             state_reg, state_next;
    logic               space_q_reg;
    logic [STEP_W-1:0]  step_cnt_reg, step_cnt_next;
    logic [THROW_W-1:0] throw_cnt_reg, throw_cnt_next;
    logic [IDLE_W-1:0]  idle_cnt_reg, idle_cnt_next;
    logic [PWR_W-1:0]   power_reg, power_next;

    logic               enable_draw_reg, enable_draw_next;
    logic [1:0]         index_reg, index_next;
    logic               space_pin_tx_reg, space_pin_tx_next;
    logic               throw_enable_reg, throw_enable_next;
    logic               turn_done_reg, turn_done_next;
    logic               timed_out_reg, timed_out_next;

    // A press is a rising level on the (already synchronised) fire key.
    logic press;
    assign press = space & ~space_q_reg;

    // Next state, counters, power and the output decode of the entered state.
    always_comb begin
        state_next        = state_reg;
        step_cnt_next     = '0;
        throw_cnt_next    = '0;
        idle_cnt_next     = '0;
        power_next        = power_reg;
        timed_out_next    = 1'b0;

        if (!my_turn) begin
            // Losing the turn aborts silently from any state.
            state_next = IDLE;
            power_next = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    power_next = '0;
                    if (press) begin
                        // A press beats a coincident timeout expiry.
                        state_next = CHARGE;
                    end else if (TIMEOUT_EN && (idle_cnt_reg == IDLE_LAST)) begin
                        state_next     = DONE;
                        timed_out_next = 1'b1;
                    end else if (TIMEOUT_EN) begin
                        idle_cnt_next = idle_cnt_reg + 1'b1;
                    end
                end
                CHARGE: begin
                    if (!space) begin
                        // Release freezes power and launches the throw.
                        state_next = THROW;
                    end else if (step_cnt_reg == STEP_LAST) begin
                        if (power_reg != PWR_MAX) begin
                            power_next = power_reg + 1'b1;
                        end
                    end else begin
                        step_cnt_next = step_cnt_reg + 1'b1;
                    end
                end
                THROW: begin
                    if (throw_cnt_reg == THROW_LAST) begin
                        state_next = DONE;
                    end else begin
                        throw_cnt_next = throw_cnt_reg + 1'b1;
                    end
                end
                DONE: begin
                    state_next = IDLE;
                    power_next = '0;
                end
                default: begin
                    state_next = IDLE;
                    power_next = '0;
                end
            endcase
        end

        enable_draw_next  = 1'b0;
        index_next        = 2'd0;
        space_pin_tx_next = 1'b0;
        throw_enable_next = 1'b0;
        turn_done_next    = 1'b0;
        case (state_next)
            CHARGE: begin
                enable_draw_next  = 1'b1;
                index_next        = 2'd1;
                space_pin_tx_next = 1'b1;
            end
            THROW: begin
                index_next        = 2'd2;
                throw_enable_next = 1'b1;
            end
            DONE: begin
                index_next     = 2'd2;
                turn_done_next = 1'b1;
            end
            default: begin
                index_next = 2'd0;
            end
        endcase
    end

    // State, counters, key history and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= IDLE;
            space_q_reg      <= 1'b0;
            step_cnt_reg     <= '0;
            throw_cnt_reg    <= '0;
            idle_cnt_reg     <= '0;
            power_reg        <= '0;
            enable_draw_reg  <= 1'b0;
            index_reg        <= 2'd0;
            space_pin_tx_reg <= 1'b0;
            throw_enable_reg <= 1'b0;
            turn_done_reg    <= 1'b0;
            timed_out_reg    <= 1'b0;
        end else begin
            state_reg        <= state_next;
            space_q_reg      <= space;
            step_cnt_reg     <= step_cnt_next;
            throw_cnt_reg    <= throw_cnt_next;
            idle_cnt_reg     <= idle_cnt_next;
            power_reg        <= power_next;
            enable_draw_reg  <= enable_draw_next;
            index_reg        <= index_next;
            space_pin_tx_reg <= space_pin_tx_next;
            throw_enable_reg <= throw_enable_next;
            turn_done_reg    <= turn_done_next;
            timed_out_reg    <= timed_out_next;
        end
    end

    assign enable_draw  = enable_draw_reg;
    assign index        = index_reg;
    assign space_pin_tx = space_pin_tx_reg;
    assign throw_enable = throw_enable_reg;
    assign power        = power_reg;
    assign turn_done    = turn_done_reg;
    assign timed_out    = timed_out_reg;

endmodule

// File: doc/turn_charge_fsm.md
TURN_CHARGE_FSM -- requirements
Module: turn_charge_fsm

Interface
REQ-001 The block SHALL be written with these parameters (name, default, meaning), one per line:
- THROW_TICKS, 65_000_000, cycles spent in THROW (1 s at 65 MHz); legal range >= 1.
- PWR_W, 8, width of the power output.
- PWR_STEP_TICKS, 250_000, cycles per +1 power step while charging; legal range >= 1.
- IDLE_TIMEOUT_TICKS, 650_000_000, cycles in IDLE before a turn is forfeited; 0 disables the timeout.
REQ-002 The block SHALL have these ports (name, direction, width, meaning), one per line:
- clk, input, 1, sole clock; all logic on its rising edge.
- rst, input, 1, synchronous active-high reset.
- space, input, 1, player fire key, level, already synchronised.
- my_turn, input, 1, high while this player owns the turn.
- enable_draw, output, 1, aim/charge sprite draw enable.
- index, output, 2, sprite frame: 0 idle, 1 charging, 2 thrown.
- space_pin_tx, output, 1, mirrors the charging state to the remote board.
- throw_enable, output, 1, projectile in flight.
- power, output, PWR_W, charge level, held through THROW and DONE.
- turn_done, output, 1, one-cycle pulse at the end of the turn.
- timed_out, output, 1, qualifies turn_done; 1 means the turn was forfeited.

Function
REQ-003 All outputs SHALL be registered; at each edge the outputs SHALL take the decode of the state being entered, so a transition and its outputs appear in the same cycle.
REQ-004 The states SHALL be IDLE, CHARGE, THROW and DONE, with these output decodes:
- IDLE: enable_draw=0, index=0, space_pin_tx=0, throw_enable=0, turn_done=0, timed_out=0.
- CHARGE: enable_draw=1, index=1, space_pin_tx=1, throw_enable=0.
- THROW: enable_draw=0, index=2, space_pin_tx=0, throw_enable=1.
- DONE: index=2, turn_done=1, all other strobes 0.
REQ-005 The block SHALL register space each cycle (space_q), and a press SHALL be defined as space=1 while space_q=0.
REQ-006 IDLE SHALL go to CHARGE only on a press while my_turn=1; a key already held when my_turn rises SHALL NOT start a turn until it has been released and pressed again.
REQ-007 On entry to CHARGE, power SHALL be 0 and the step counter SHALL be cleared.
REQ-008 While in CHARGE, power SHALL increment by 1 every PWR_STEP_TICKS cycles and SHALL saturate at 2^PWR_W-1 without wrapping.
REQ-009 CHARGE SHALL go to THROW on the first cycle space=0, and power SHALL freeze at that edge.
REQ-010 THROW SHALL last exactly THROW_TICKS cycles and then go to DONE; the tick counter SHALL be clear on entry.
REQ-011 DONE SHALL last exactly one cycle and then go to IDLE; power SHALL hold its value through DONE and clear on the return to IDLE.
REQ-012 When IDLE_TIMEOUT_TICKS > 0, my_turn=1 and no press occurs, IDLE SHALL count cycles; after IDLE_TIMEOUT_TICKS cycles it SHALL enter DONE with timed_out=1 and power=0.
REQ-013 The idle counter SHALL clear whenever my_turn=0 or the block leaves IDLE.
REQ-014 If my_turn=0 in any state, the next edge SHALL force IDLE, clear all outputs, clear power and clear all counters; no turn_done pulse SHALL be issued.
REQ-015 If a press and the timeout expiry occur in the same cycle, the press SHALL win and the block SHALL go to CHARGE.
REQ-016 A change on space during THROW or DONE SHALL be ignored.
REQ-017 Counters SHALL be sized with $clog2 of their parameter, minimum 1 bit, and SHALL NOT overflow at legal parameter values.
REQ-018 An unreachable state encoding SHALL return to IDLE on the next edge.

Reset
REQ-019 While rst=1, the block SHALL take state IDLE and drive every output and counter to 0, including space_q.
REQ-020 rst SHALL take priority over my_turn and space and SHALL abort any state mid-operation.

Verification
Benches run with THROW_TICKS=4, PWR_STEP_TICKS=2, PWR_W=3, IDLE_TIMEOUT_TICKS=10.
REQ-021 Basic turn: my_turn=1, space high for 5 cycles then low -> index=1 for 5 cycles and power reaches 2; then index=2 with throw_enable=1 for exactly 4 cycles; then a turn_done pulse of 1 cycle with timed_out=0.
REQ-022 Saturation: space held for 30 cycles -> power saturates at 7 and holds through THROW and DONE.
REQ-023 Held key: space=1 before my_turn rises and kept high for 6 cycles -> state stays IDLE; a release and re-press then starts CHARGE.
REQ-024 Timeout: my_turn=1, no press -> turn_done=1 and timed_out=1 on the 10th cycle, power=0; a press on that same cycle -> CHARGE, no turn_done.
REQ-025 Abort: my_turn dropped during THROW -> all outputs 0 on the next cycle and no turn_done; rst asserted during CHARGE -> all outputs 0 on the next cycle.
